// File: rtl/digits_to_time.sv
// rtl/digits_to_time.sv - assembles four BCD digits (mm:ss) into binary minutes/seconds
// Optional inter-digit timeout compiled in with `define DIGITS_TIMEOUT_EN.
module digits_to_time #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       digit_ready,
  input  logic       abort,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       time_valid,
  output logic       error,
  output logic [2:0] digit_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min1_q, min1_d, min0_q, min0_d;
  logic [3:0] sec1_q, sec1_d, sec0_q, sec0_d;
  logic [2:0] count_q, count_d;
  logic [6:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;
  logic       time_valid_q, time_valid_d;
  logic       error_q, error_d;

  logic       accept;
  logic       bad_digit;
  logic       take;
  logic       timeout_hit;
  logic [6:0] min1_w;
  logic [5:0] sec1_w;

  // abort wins over a simultaneous digit, so a digit under abort is never accepted
  assign accept    = digit_valid && digit_ready && !abort;
  assign bad_digit = (digit > 4'd9) || ((count_q == 3'd2) && (digit > 4'd5));
  assign take      = accept && !bad_digit;

`ifdef DIGITS_TIMEOUT_EN
  logic [23:0] timer_q, timer_d;

  assign timeout_hit = (state_q == S_ENTRY) && !accept && !abort &&
                       (timer_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    timer_d = 24'd0;
    if (state_q == S_ENTRY && !accept && !abort && !timeout_hit) begin
      timer_d = timer_q + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= 24'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (abort || (accept && bad_digit) || timeout_hit) begin
          state_d = S_IDLE;
        end else if (take && count_q == 3'd3) begin
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    digit_ready = 1'b0;
    case (state_q)
      S_IDLE, S_ENTRY: digit_ready = 1'b1;
      default:         digit_ready = 1'b0;
    endcase
  end

  assign min1_w = {3'b000, min1_q};
  assign sec1_w = {2'b00, sec1_q};

  always_comb begin
    min1_d       = min1_q;
    min0_d       = min0_q;
    sec1_d       = sec1_q;
    sec0_d       = sec0_q;
    count_d      = count_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    time_valid_d = 1'b0;
    error_d      = 1'b0;

    if (state_q == S_CONVERT) begin
      minutes_d    = (min1_w << 3) + (min1_w << 1) + {3'b000, min0_q};
      seconds_d    = (sec1_w << 3) + (sec1_w << 1) + {2'b00, sec0_q};
      time_valid_d = 1'b1;
      count_d      = 3'd0;
    end else if (abort) begin
      count_d = 3'd0;
    end else if ((accept && bad_digit) || timeout_hit) begin
      error_d = 1'b1;
      count_d = 3'd0;
    end else if (take) begin
      count_d = count_q + 3'd1;
      case (count_q)
        3'd0:    min1_d = digit;
        3'd1:    min0_d = digit;
        3'd2:    sec1_d = digit;
        default: sec0_d = digit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min1_q       <= 4'd0;
      min0_q       <= 4'd0;
      sec1_q       <= 4'd0;
      sec0_q       <= 4'd0;
      count_q      <= 3'd0;
      minutes_q    <= 7'd0;
      seconds_q    <= 6'd0;
      time_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      min1_q       <= min1_d;
      min0_q       <= min0_d;
      sec1_q       <= sec1_d;
      sec0_q       <= sec0_d;
      count_q      <= count_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      time_valid_q <= time_valid_d;
      error_q      <= error_d;
    end
  end

  assign minutes     = minutes_q;
  assign seconds     = seconds_q;
  assign time_valid  = time_valid_q;
  assign error       = error_q;
  assign digit_count = count_q;

endmodule
